// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared parameters and FSM state type for the bitstream frame receiver
package bitstream_pkg;
    localparam int PAYLOAD_W_DEF = 64;
    localparam int CRC_W_DEF     = 8;
    localparam int ERR_CNT_W     = 16;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } rx_state_e;
endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - position of the next accepted bit within a payload+CRC frame
module frame_bit_counter #(
    parameter int PAYLOAD_W = 64,
    parameter int FRAME_W   = 72,
    localparam int CNT_W    = $clog2(FRAME_W)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             in_payload
);
    assign last       = (cnt == CNT_W'(FRAME_W - 1));
    assign in_payload = (cnt <  CNT_W'(PAYLOAD_W));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bitstream_frame_rx.sv
// rtl/bitstream_frame_rx.sv - serial frame receiver feeding crc_8; FRAME_RX_ERR_CNT_EN adds err_cnt_o
module bitstream_frame_rx
    import bitstream_pkg::*;
#(
    parameter int  PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int  CRC_W     = CRC_W_DEF,
    localparam int FRAME_W   = PAYLOAD_W + CRC_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 bit_i,
    input  logic                 bit_valid_i,
    output logic                 bit_ready_o,
    output logic                 crc_en_o,
    output logic                 crc_data_o,
    output logic                 crc_capture_o,
    input  logic                 crc_flag_i,
    output logic [PAYLOAD_W-1:0] word_o,
`ifdef FRAME_RX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic                 frame_err_o
);
    localparam int CNT_W = $clog2(FRAME_W);

    rx_state_e            state;
    logic [PAYLOAD_W-1:0] word_q;
    logic                 word_valid_q;
    logic [CNT_W-1:0]     cnt;
    logic                 last;
    logic                 in_payload;
    logic                 accept;

    // Ready is gated by reset and clear so nothing is ever handed over while the block is being aborted.
    assign bit_ready_o   = rst_ni && (state == RECV) && !clear_i;
    assign accept        = bit_valid_i && bit_ready_o;
    assign crc_data_o    = bit_i && bit_ready_o;
    assign crc_en_o      = accept && !last;
    assign crc_capture_o = accept && last;
    assign frame_err_o   = (state == CHECK) && crc_flag_i && !clear_i;
    assign word_o        = word_q;
    assign word_valid_o  = word_valid_q;

    frame_bit_counter #(
        .PAYLOAD_W (PAYLOAD_W),
        .FRAME_W   (FRAME_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc        (accept),
        .clr        (clear_i),
        .cnt        (cnt),
        .last       (last),
        .in_payload (in_payload)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= RECV;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else if (clear_i) begin
            state        <= RECV;
            word_valid_q <= 1'b0;
        end else begin
            unique case (state)
                RECV: begin
                    for (int i = 0; i < PAYLOAD_W; i++) begin
                        if (accept && in_payload && cnt == CNT_W'(i)) begin
                            word_q[i] <= bit_i;
                        end
                    end
                    if (accept && last) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (crc_flag_i) begin
                        state <= RECV;
                    end else begin
                        state        <= HOLD;
                        word_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (word_ready_i) begin
                        state        <= RECV;
                        word_valid_q <= 1'b0;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

`ifdef FRAME_RX_ERR_CNT_EN
    // Survives clear_i on purpose: it is a lifetime statistic, only reset wipes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (frame_err_o && err_cnt_o != {ERR_CNT_W{1'b1}}) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bitstream_frame_rx.sv
// tb/tb_bitstream_frame_rx.sv - self-checking bench for bitstream_frame_rx
module tb_bitstream_frame_rx;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic        bit_ready_o;
    logic        crc_en_o, crc_data_o, crc_capture_o;
    logic        crc_flag_i = 1'b0;
    logic [63:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b0;
    logic        frame_err_o;
`ifdef FRAME_RX_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bitstream_frame_rx dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .bit_i         (bit_i),
        .bit_valid_i   (bit_valid_i),
        .bit_ready_o   (bit_ready_o),
        .crc_en_o      (crc_en_o),
        .crc_data_o    (crc_data_o),
        .crc_capture_o (crc_capture_o),
        .crc_flag_i    (crc_flag_i),
        .word_o        (word_o),
`ifdef FRAME_RX_ERR_CNT_EN
        .err_cnt_o     (err_cnt_o),
`endif
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .frame_err_o   (frame_err_o)
    );

    typedef struct {
        logic [63:0] payload;
        logic [7:0]  crc;
        logic        flag;
        int          gap_pct;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] word;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   gap_viol = 0;
    int   data_bad = 0;
    int   exp_err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every handshake or error pulse consumes one expected result.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (word_valid_o && word_ready_i) begin
                check("sb_has_word", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("word_not_err", 64'(e.err), 64'd0);
                    check("word_value", word_o, e.word);
                end
            end
            if (frame_err_o) begin
                check("sb_has_err", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("err_expected", 64'(e.err), 64'd1);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int gap_pct, output logic en, output logic cap);
        int guard;
        guard = 0;
        en = 1'b0;
        cap = 1'b0;
        bit_i = b;
        forever begin
            bit_valid_i = ($urandom_range(99) >= gap_pct);
            @(negedge clk_i);
            if (!bit_valid_i && (crc_en_o || crc_capture_o)) gap_viol++;
            if (bit_valid_i && bit_ready_o) begin
                en = crc_en_o;
                cap = crc_capture_o;
                if (crc_data_o !== b) data_bad++;
                @(posedge clk_i); #1;
                bit_valid_i = 1'b0;
                break;
            end
            @(posedge clk_i); #1;
            guard++;
            if (guard > 200) begin
                check("bit_accept_timeout", 64'(guard), 64'd0);
                bit_valid_i = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [63:0] pl, input logic [7:0] crc, input logic flag,
                             input int gap, input int hold, input bit handshake);
        logic [71:0] fr;
        int          en_cnt, cap_cnt;
        logic        en, cap, cap_last;
        exp_t        e;
        fr = {crc, pl};
        en_cnt = 0;
        cap_cnt = 0;
        cap_last = 1'b0;
        gap_viol = 0;
        data_bad = 0;
        if (handshake || flag) begin
            e.word = pl;
            e.err = flag;
            sb.push_back(e);
        end
        for (int k = 0; k < 72; k++) begin
            send_bit(fr[k], gap, en, cap);
            en_cnt += int'(en);
            cap_cnt += int'(cap);
            if (k == 71) cap_last = cap;
        end
        check("crc_en_count", 64'(en_cnt), 64'd71);
        check("capture_count", 64'(cap_cnt), 64'd1);
        check("capture_on_last", 64'(cap_last), 64'd1);
        check("no_en_in_gap", 64'(gap_viol), 64'd0);
        check("crc_data_follows_bit", 64'(data_bad), 64'd0);
        crc_flag_i = flag;
        @(negedge clk_i);
        check("ready_low_in_check", 64'(bit_ready_o), 64'd0);
        check("no_crc_in_check", 64'({crc_en_o, crc_capture_o}), 64'd0);
        @(posedge clk_i); #1;
        crc_flag_i = 1'b0;
        @(negedge clk_i);
        if (flag) begin
            check("ready_after_err", 64'(bit_ready_o), 64'd1);
            check("no_valid_after_err", 64'(word_valid_o), 64'd0);
            check("err_single_cycle", 64'(frame_err_o), 64'd0);
            exp_err_cnt++;
`ifdef FRAME_RX_ERR_CNT_EN
            check("err_cnt", 64'(err_cnt_o), 64'(exp_err_cnt));
`endif
        end else begin
            check("valid_latency", 64'(word_valid_o), 64'd1);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                check("ready_low_in_hold", 64'(bit_ready_o), 64'd0);
                check("word_stable_in_hold", word_o, pl);
            end
            if (handshake) begin
                @(posedge clk_i); #1;
                word_ready_i = 1'b1;
                @(negedge clk_i);
                @(posedge clk_i); #1;
                word_ready_i = 1'b0;
                @(negedge clk_i);
                check("ready_after_handshake", 64'(bit_ready_o), 64'd1);
                check("valid_drop_after_hs", 64'(word_valid_o), 64'd0);
            end
        end
        @(posedge clk_i); #1;
    endtask

    vec_t vecs[6];

    initial begin
        logic en, cap;
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FF69, 8'h7F, 1'b0, 0,  0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FF69, 8'h7F, 1'b1, 0,  0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FF69, 8'h7F, 1'b0, 50, 0};
        vecs[3] = '{64'hA5C3_0F1E_8D72_4B96, 8'h3C, 1'b0, 0,  10};
        vecs[4] = '{64'h0000_0000_0000_0000, 8'hFF, 1'b0, 30, 2};
        vecs[5] = '{64'h8000_0000_0000_0001, 8'h01, 1'b1, 20, 0};

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(bit_ready_o), 64'd0);
        check("rst_valid", 64'(word_valid_o), 64'd0);
        check("rst_err", 64'(frame_err_o), 64'd0);
        check("rst_crc", 64'({crc_en_o, crc_capture_o, crc_data_o}), 64'd0);
        check("rst_word", word_o, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", 64'(bit_ready_o), 64'd1);
        @(posedge clk_i); #1;

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].payload, vecs[v].crc, vecs[v].flag, vecs[v].gap_pct, vecs[v].hold, 1'b1);
        end

        // Abort at bit 40, then a full fresh frame must land with capture on its own 72nd bit.
        for (int k = 0; k < 40; k++) send_bit(1'b1, 0, en, cap);
        clear_i = 1'b1;
        bit_valid_i = 1'b1;
        @(negedge clk_i);
        check("clear_blocks_crc", 64'({crc_en_o, crc_capture_o}), 64'd0);
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        bit_valid_i = 1'b0;
        run_frame(64'h1234_5678_9ABC_DEF0, 8'h55, 1'b0, 0, 0, 1'b1);

        // Reset while holding an unconsumed word.
        run_frame(64'hDEAD_BEEF_CAFE_F00D, 8'hAA, 1'b0, 0, 2, 1'b0);
        check("valid_before_rst", 64'(word_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_drops_valid", 64'(word_valid_o), 64'd0);
        check("rst_drops_err", 64'(frame_err_o), 64'd0);
        check("rst_drops_crc", 64'({crc_en_o, crc_capture_o, crc_data_o}), 64'd0);
        check("rst_drops_ready", 64'(bit_ready_o), 64'd0);
        exp_err_cnt = 0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_frame(64'h0F0F_F0F0_3333_CCCC, 8'h12, 1'b0, 10, 0, 1'b1);
        run_frame(64'h0F0F_F0F0_3333_CCCC, 8'h12, 1'b1, 0, 0, 1'b1);

        repeat (3) @(posedge clk_i);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bitstream_frame_rx.md
Name: bitstream_frame_rx

Overview:
- Serial-to-parallel frame receiver that sits directly upstream of crc_8 in the secured-bitstream loader.
- Accepts the raw serial bitstream one bit per handshake and cuts it into fixed frames of payload plus CRC-8 bits.
- Drives crc_8's en_i, data_i and capture, then reads back its flag_o.
- Releases each frame's payload as a parallel word with a valid/ready handshake, or drops the frame and raises an error pulse.

Parameters:
- PAYLOAD_W, 64, payload bits per frame.
- CRC_W, 8, CRC bits appended after the payload.
- FRAME_W, PAYLOAD_W+CRC_W (72), total bits per frame; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous abort of the current frame.
- bit_i  in  1  serial bitstream bit.
- bit_valid_i  in  1  bit_i valid this cycle.
- bit_ready_o  out  1  receiver accepts a bit this cycle.
- crc_en_o  out  1  to crc_8 en_i.
- crc_data_o  out  1  to crc_8 data_i.
- crc_capture_o  out  1  to crc_8 capture.
- crc_flag_i  in  1  from crc_8 flag_o; 1 = CRC mismatch.
- word_o  out  PAYLOAD_W  received payload.
- word_valid_o  out  1  word_o valid.
- word_ready_i  in  1  consumer accepts word_o.
- frame_err_o  out  1  one-cycle pulse on CRC mismatch.

Behaviour:
- Reset: asynchronous and active-low. All outputs go to 0; state=RECV; bit counter=0; shift register=0.
- States:
  - RECV: bit_ready_o=1. A bit is accepted when bit_valid_i && bit_ready_o.
  - CHECK: exactly one cycle.
  - HOLD: word_valid_o=1.
- Bit order: LSB-first. Accepted bit k (0-based within the frame), for k<PAYLOAD_W, is written to word register bit k. CRC bits are forwarded to the CRC unit only and never stored.
- crc_data_o = bit_i, combinational.
- crc_en_o = accept && cnt<FRAME_W-1.
- crc_capture_o = accept && cnt==FRAME_W-1.
- On the last bit, en is 0 and capture is 1 in the same cycle. This matches the crc_8 protocol.
- Gaps: while bit_valid_i=0, crc_en_o=0 and the counter holds. Gaps of any length between bits are legal.
- On the last-bit accept: cnt goes to 0, state goes to CHECK.
- In CHECK: bit_ready_o=0, crc_* outputs = 0, crc_flag_i is sampled.
  - flag=1: frame_err_o pulses for that single cycle, the word is discarded, next state is RECV.
  - flag=0: next state is HOLD.
- HOLD: bit_ready_o=0. On word_valid_o && word_ready_i, next state is RECV.
- Latency: word_valid_o rises 2 cycles after the cycle in which the last bit is accepted. RECV resumes the cycle after the handshake.
- Backpressure: bits are stalled (bit_ready_o=0) for the whole of CHECK and HOLD. No frame overlap.
- clear_i has priority over everything in any state:
  - cnt := 0, state := RECV, word_valid_o := 0, frame_err_o := 0.
  - crc_en_o and crc_capture_o are forced 0 that cycle.
- Reset asserted mid-frame discards the partial frame immediately.
- crc_8 internal state is the CRC block's concern; this block guarantees no en/capture during CHECK, HOLD and clear.

Optional Feature:
- Macro: FRAME_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt_o, 16 bits.
  - Increments on each frame_err_o pulse and saturates at 16'hFFFF.
  - Cleared by reset only; clear_i does not affect it.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package bitstream_pkg holds:
  - PAYLOAD_W_DEF=64, CRC_W_DEF=8.
  - State enum rx_state_e {RECV, CHECK, HOLD}.
  - ERR_CNT_W=16.
- One natural sub-module: frame_bit_counter. Width $clog2(FRAME_W), with inputs inc and clr, and outputs last and in_payload.
- The shift/hold register and FSM stay in the top.

Test Plan:
- Frame 72'b0111...01101001, LSB-first, no gaps, crc_flag_i=0 → crc_en_o high 71 accepted bits; capture high with bit 71 only. word_o=frame[63:0], word_valid_o high 2 cycles after the last bit.
- Same frame, crc_flag_i=1 in CHECK → frame_err_o pulses exactly 1 cycle, word_valid_o stays 0, bit_ready_o returns 1 next cycle. With FRAME_RX_ERR_CNT_EN, err_cnt_o=1.
- bit_valid_i toggling 50% random across a frame → same word_o as the no-gap case. crc_en_o never high while bit_valid_i=0.
- word_ready_i held 0 for 10 cycles after a good frame → bit_ready_o=0 and word_o stable throughout. The handshake on cycle 11 returns to RECV.
- clear_i at bit 40 of a frame, then a full new frame → the first frame never produces a word. The second frame yields its correct word, with capture on its own 72nd bit.
- rst_ni low for 1 cycle mid-HOLD → word_valid_o, frame_err_o and crc_* drop to 0 immediately. The next 72 bits form a fresh frame.
